alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: requester holding priority after reset (0 or 1).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  2  per-requester operation request.
REQ-006 req_ready  output  2  per-requester accept strobe, one-hot or zero.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  32 each  operands of requester 0 and requester 1.
REQ-008 req_shamt0, req_shamt1  input  5 each  immediate shift amounts.
REQ-009 req_sel0, req_sel1  input  4 each  ALU op code (0 add … 11 auipc).
REQ-010 req_bsel0, req_bsel1  input  1 each  1 = use shamt for shifts.
REQ-011 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-012 alu_shamt  output  5; alu_sel  output  4; alu_bsel  output  1  shared ALU controls.
REQ-013 alu_out  input  32  combinational result from the shared ALU.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_id  output  1  requester that owns rsp_data.
REQ-017 rsp_data  output  32  registered result.
REQ-018 rsp_err  output  1  op code was illegal (sel > 11).

Function
REQ-019 FSM states SHALL be IDLE, EXEC and RESP, encoded in 2 bits; encoding 3 SHALL return to IDLE.
REQ-020 In IDLE with any req_valid set, req_ready SHALL assert combinationally, in the same cycle, for exactly one requester chosen by round-robin.
REQ-021 Round-robin rule: if both requesters are valid, grant the requester other than last_grant; if only one is valid, grant that one.
REQ-022 On a grant, the operands, shamt, sel, bsel and id SHALL be captured into an op register, and the FSM SHALL move to EXEC.
REQ-023 req_ready SHALL be 0 in EXEC and RESP, and in IDLE when no request is valid.
REQ-024 alu_* outputs SHALL always be driven from the op register; they are 0 after reset.
REQ-025 In EXEC, alu_out SHALL be registered into rsp_data, rsp_err SHALL be set to (sel > 11), and the FSM SHALL move to RESP.
REQ-026 When rsp_err is set, rsp_data SHALL be 0 instead of alu_out.
REQ-027 In RESP, rsp_valid SHALL be 1; rsp_data, rsp_id and rsp_err SHALL stay stable until rsp_ready is sampled high.
REQ-028 On RESP with rsp_ready high, last_grant SHALL take the value of rsp_id, rsp_valid SHALL drop next cycle, and the FSM SHALL return to IDLE.
REQ-029 No same-cycle bypass: a new grant SHALL NOT occur in the RESP-exit cycle.
REQ-030 Latency: for a grant in cycle N, rsp_valid SHALL be 1 from cycle N+2; minimum issue interval is 3 cycles.
REQ-031 Changes on req_* inputs after a grant SHALL NOT affect the in-flight operation.
REQ-032 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-033 On rst, asynchronously: FSM=IDLE, last_grant=~RR_INIT, op register=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0; req_ready is then 0 until a request arrives.
REQ-034 A reset during EXEC or RESP SHALL discard the in-flight operation without producing a response.

Verification
REQ-035 Single add: req_valid=01, a0=5, b0=7, sel0=0 -> req_ready=01 in cycle N; alu_a=5, alu_b=7 in N+1; rsp_valid=1, rsp_data=12, rsp_id=0 at N+2.
REQ-036 Contention: both requesters valid continuously after reset with RR_INIT=0, rsp_ready=1 -> grant sequence 0,1,0,1; ops spaced 3 cycles apart.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data held stable, req_ready=00 throughout; the next grant comes one cycle after the rsp_ready handshake.
REQ-038 Illegal op: sel1=13, req_valid=10 -> rsp_err=1, rsp_data=0, rsp_id=1.
REQ-039 Shift/sub: sel0=7, a0=0x80000000, bsel0=1, shamt0=4 -> rsp_data=0xF8000000; sel1=1, a1=3, b1=5 -> rsp_data=0xFFFFFFFE.
REQ-040 Reset mid-operation: assert rst during EXEC -> no rsp_valid; after release, a request from requester 0 with only it valid is granted, and RR order restarts from RR_INIT.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared, combinational ALU.
// Each operation is granted, executed for one cycle, then held as a response until it is accepted.
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [4:0]  req_shamt0,
  input  logic [4:0]  req_shamt1,
  input  logic [3:0]  req_sel0,
  input  logic [3:0]  req_sel1,
  input  logic        req_bsel0,
  input  logic        req_bsel1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_sel,
  output logic        alu_bsel,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic [31:0] op_a_reg;
  logic [31:0] op_b_reg;
  logic [4:0]  op_shamt_reg;
  logic [3:0]  op_sel_reg;
  logic        op_bsel_reg;
  logic        op_id_reg;
  logic        rsp_valid_reg;
  logic        rsp_id_reg;
  logic [31:0] rsp_data_reg;
  logic        rsp_err_reg;

  logic [31:0] in_a [2];
  logic [31:0] in_b [2];
  logic [4:0]  in_shamt [2];
  logic [3:0]  in_sel [2];
  logic        in_bsel [2];

  logic grant_any;
  logic grant_id;
  logic op_illegal;

  assign in_a[0]     = req_a0;
  assign in_a[1]     = req_a1;
  assign in_b[0]     = req_b0;
  assign in_b[1]     = req_b1;
  assign in_shamt[0] = req_shamt0;
  assign in_shamt[1] = req_shamt1;
  assign in_sel[0]   = req_sel0;
  assign in_sel[1]   = req_sel1;
  assign in_bsel[0]  = req_bsel0;
  assign in_bsel[1]  = req_bsel1;

  // Under contention the requester not served last wins; otherwise the lone requester wins.
  always_comb begin
    grant_any = (state_reg == IDLE) && (req_valid != 2'b00);
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = req_valid[1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = grant_any && (grant_id == 1'(gi));
    end
  endgenerate

  assign op_illegal = (op_sel_reg > 4'd11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= ~RR_INIT;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_shamt_reg   <= '0;
      op_sel_reg     <= '0;
      op_bsel_reg    <= 1'b0;
      op_id_reg      <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            op_a_reg     <= in_a[grant_id];
            op_b_reg     <= in_b[grant_id];
            op_shamt_reg <= in_shamt[grant_id];
            op_sel_reg   <= in_sel[grant_id];
            op_bsel_reg  <= in_bsel[grant_id];
            op_id_reg    <= grant_id;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_reg  <= op_illegal ? 32'd0 : alu_out;
          rsp_err_reg   <= op_illegal;
          rsp_id_reg    <= op_id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            last_grant_reg <= rsp_id_reg;
            rsp_valid_reg  <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_a     = op_a_reg;
  assign alu_b     = op_b_reg;
  assign alu_shamt = op_shamt_reg;
  assign alu_sel   = op_sel_reg;
  assign alu_bsel  = op_bsel_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
